// File: rtl/eth_tx_fcs.sv
// ============================================================================
// eth_tx_fcs
// ----------------------------------------------------------------------------
// CRC-32 Frame Check Sequence engine for the RMII transmit path.
//
// The transmit controller feeds every dibit it puts on the wire (destination
// address through pad) into this block while Crc_En is high. On Fcs_Start the
// complemented CRC is latched into a shift register and played out as 16
// dibits, LSB first, for the controller to drive onto Tx_Data.
//
// The CRC is kept in reflected form, so the bit transmitted first is folded
// in first and the FCS leaves the shift register from bit 0 upward.
//
// Ports
//   Clk        in   1   50 MHz RMII reference clock
//   Rst        in   1   Synchronous, active-high reset
//   Crc_Init   in   1   Pulse: preset CRC to pCRC_INIT and enter ACCUM
//   Crc_En     in   1   Crc_Data is valid this cycle; fold it into the CRC
//   Crc_Data   in   2   Tx dibit; bit[0] is transmitted first
//   Fcs_Start  in   1   Pulse: latch ~CRC and begin emitting the FCS
//   Fcs_Data   out  2   FCS dibit, bit[0] first; 0 while Fcs_Valid is low
//   Fcs_Valid  out  1   Fcs_Data valid; high for exactly 16 cycles per FCS
//   Fcs_Done   out  1   One-cycle pulse with the 16th (last) FCS dibit
//   Busy       out  1   High in ACCUM or EMIT
//   Crc_Value  out  32  Raw (uncomplemented) CRC register
// ============================================================================
module eth_tx_fcs #(
    parameter logic [31:0] pCRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] pCRC_POLY = 32'hEDB88320
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Crc_Init,
    input  logic        Crc_En,
    input  logic [1:0]  Crc_Data,
    input  logic        Fcs_Start,
    output logic [1:0]  Fcs_Data,
    output logic        Fcs_Valid,
    output logic        Fcs_Done,
    output logic        Busy,
    output logic [31:0] Crc_Value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } tState;

    tState       state, stateNext;
    logic [31:0] crcReg, crcNext;
    logic [31:0] crcStep;
    logic [31:0] shiftReg, shiftNext;
    logic [3:0]  dibitCnt, dibitCntNext;
    logic [1:0]  fcsDataNext;
    logic        fcsValidNext;
    logic        fcsDoneNext;

    // Two reflected single-bit steps: Crc_Data[0] goes in first because it is
    // the first bit on the wire.
    function automatic logic [31:0] nextCrc(input logic [31:0] crc,
                                            input logic [1:0]  dibit);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            fb = c[0] ^ dibit[i];
            c  = (c >> 1) ^ (fb ? pCRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    assign crcStep = nextCrc(crcReg, Crc_Data);

    // ------------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        stateNext    = state;
        crcNext      = crcReg;
        shiftNext    = shiftReg;
        dibitCntNext = dibitCnt;
        fcsDataNext  = 2'b00;
        fcsValidNext = 1'b0;
        fcsDoneNext  = 1'b0;

        if (Crc_Init) begin
            // Wins over everything else, including an FCS in flight: the
            // output registers fall back to their defaults (abort).
            crcNext   = pCRC_INIT;
            stateNext = ACCUM;
        end else begin
            unique case (state)
                IDLE: begin
                    // Crc_En and Fcs_Start are ignored until a frame opens.
                end

                ACCUM: begin
                    if (Crc_En) begin
                        crcNext = crcStep;
                    end
                    if (Fcs_Start) begin
                        // A dibit accompanying Fcs_Start is the last data
                        // dibit and must be covered by the FCS.
                        shiftNext    = Crc_En ? ~crcStep : ~crcReg;
                        dibitCntNext = 4'd0;
                        stateNext    = EMIT;
                    end
                end

                EMIT: begin
                    fcsDataNext  = shiftReg[1:0];
                    fcsValidNext = 1'b1;
                    shiftNext    = shiftReg >> 2;
                    dibitCntNext = dibitCnt + 4'd1;
                    if (dibitCnt == 4'd15) begin
                        fcsDoneNext = 1'b1;
                        stateNext   = IDLE;
                    end
                end

                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (Rst) begin
            // NOTE: the shift register and counter are plain flops (no RAM),
            // so they are reset along with the control state to keep the
            // datapath free of X after power-up.
            state     <= IDLE;
            crcReg    <= pCRC_INIT;
            shiftReg  <= 32'h0000_0000;
            dibitCnt  <= 4'd0;
            Fcs_Data  <= 2'b00;
            Fcs_Valid <= 1'b0;
            Fcs_Done  <= 1'b0;
        end else begin
            state     <= stateNext;
            crcReg    <= crcNext;
            shiftReg  <= shiftNext;
            dibitCnt  <= dibitCntNext;
            Fcs_Data  <= fcsDataNext;
            Fcs_Valid <= fcsValidNext;
            Fcs_Done  <= fcsDoneNext;
        end
    end

    assign Busy      = (state != IDLE);
    assign Crc_Value = crcReg;

endmodule
